// File: rtl/video_source_router.sv
// video_source_router: routes any of NUM_SOURCES ADC pixel FIFOs to frame-aligned bg/fg consumers.
// Unselected FIFOs are drained every cycle so they never overflow.
module video_source_router #(
    parameter int NUM_SOURCES = 2,
    parameter int PRECISION   = 11,
    parameter int PIXEL_SIZE  = 16,
    parameter int SEL_WIDTH   = 3,
    parameter int WORD_W      = 2*PRECISION+PIXEL_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SOURCES*WORD_W-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]        src_empty,
    output logic [NUM_SOURCES-1:0]        src_read,
    input  logic [SEL_WIDTH-1:0]          bg_sel,
    input  logic [SEL_WIDTH-1:0]          fg_sel,
    output logic [WORD_W-1:0]             bg_data,
    output logic                          bg_valid,
    input  logic                          bg_ready,
    output logic [WORD_W-1:0]             fg_data,
    output logic                          fg_valid,
    input  logic                          fg_ready,
    output logic                          bg_locked,
    output logic                          fg_locked,
    output logic [15:0]                   bg_discard_cnt,
    output logic [15:0]                   fg_discard_cnt
);
    typedef enum logic {SYNC, RUN} state_t;
    state_t                 state [2];
    state_t                 state_next [2];
    logic [SEL_WIDTH-1:0]   sel [2];
    logic [SEL_WIDTH-1:0]   active [2];
    logic [WORD_W-1:0]      data [2];
    logic [WORD_W-1:0]      head [2];
    logic [15:0]            cnt [2];
    logic [NUM_SOURCES-1:0] own [2];
    logic                   valid [2];
    logic                   ready [2];
    logic                   can [2];
    logic                   stable [2];
    logic                   pop [2];
    logic                   start [2];
    logic                   load [2];
    assign sel[0]         = bg_sel;
    assign sel[1]         = fg_sel;
    assign ready[0]       = bg_ready;
    assign ready[1]       = fg_ready;
    assign bg_data        = data[0];
    assign fg_data        = data[1];
    assign bg_valid       = valid[0];
    assign fg_valid       = valid[1];
    assign bg_locked      = state[0] == RUN;
    assign fg_locked      = state[1] == RUN;
    assign bg_discard_cnt = cnt[0];
    assign fg_discard_cnt = cnt[1];
    // An output owns a source only while its select is stable; out-of-range selects own nothing.
    always_comb begin
        src_read = '0;
        for (int o = 0; o < 2; o++) begin
            stable[o] = sel[o] == active[o];
            can[o]    = ~valid[o] | ready[o];
            head[o]   = '0;
            own[o]    = '0;
            for (int s = 0; s < NUM_SOURCES; s++) begin
                own[o][s] = stable[o] && active[o] == SEL_WIDTH'(s);
                if (own[o][s]) head[o] = src_data[s*WORD_W +: WORD_W];
            end
        end
        for (int s = 0; s < NUM_SOURCES; s++)
            src_read[s] = ~src_empty[s] & (~own[0][s] | can[0]) & (~own[1][s] | can[1]);
        for (int o = 0; o < 2; o++) begin
            pop[o]        = |(own[o] & src_read);
            start[o]      = head[o][WORD_W-1 -: 2*PRECISION] == '0;
            load[o]       = pop[o] && (state[o] == RUN || start[o]);
            state_next[o] = !stable[o] ? SYNC : (pop[o] && start[o]) ? RUN : state[o];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state <= '{SYNC, SYNC};
        else     state <= state_next;
    end
    always_ff @(posedge clk) begin
        for (int o = 0; o < 2; o++) begin
            active[o] <= sel[o];
            if (rst) begin
                valid[o] <= 1'b0;
                data[o]  <= '0;
                cnt[o]   <= '0;
            end else begin
                valid[o] <= load[o] | (valid[o] & ~ready[o]);
                if (load[o]) data[o] <= head[o];
                if (!stable[o]) cnt[o] <= '0;
                else if (pop[o] && state[o] == SYNC && !start[o] && cnt[o] != 16'hFFFF) cnt[o] <= cnt[o] + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_video_source_router.sv
// tb_video_source_router: randomized scoreboard bench with a frame-level reference model.
module tb_video_source_router;
    localparam int N = 2, P = 11, PX = 16, SW = 3, W = 2*P+PX;
    logic clk = 1'b0;
    logic rst;
    logic [N*W-1:0] src_data;
    logic [N-1:0] src_empty, src_read;
    logic [SW-1:0] bg_sel, fg_sel;
    logic [W-1:0] bg_data, fg_data;
    logic bg_valid, bg_ready, fg_valid, fg_ready, bg_locked, fg_locked;
    logic [15:0] bg_discard_cnt, fg_discard_cnt;
    int checks = 0, failures = 0, xfers = 0;
    bit junk_only = 0;
    logic [W-1:0] fifo [N][$];
    logic [W-1:0] exp_q [2][$];
    int act_m [2];
    int cnt_m [2];
    bit synced [2];
    bit held [2];

    video_source_router #(.NUM_SOURCES(N), .PRECISION(P), .PIXEL_SIZE(PX), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .src_empty(src_empty), .src_read(src_read),
        .bg_sel(bg_sel), .fg_sel(fg_sel), .bg_data(bg_data), .bg_valid(bg_valid), .bg_ready(bg_ready),
        .fg_data(fg_data), .fg_valid(fg_valid), .fg_ready(fg_ready), .bg_locked(bg_locked),
        .fg_locked(fg_locked), .bg_discard_cnt(bg_discard_cnt), .fg_discard_cnt(fg_discard_cnt));

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(int x, int y);
        return {P'(x), P'(y), PX'($urandom)};
    endfunction

    // Sources carry tiny 3x2 frames interleaved with non-frame-start junk words.
    task automatic refill(int s);
        while (fifo[s].size() < 4) begin
            if (junk_only || $urandom_range(0, 2) == 0)
                fifo[s].push_back(mk($urandom_range(1, 50), $urandom_range(0, 50)));
            else
                for (int y = 0; y < 2; y++)
                    for (int x = 0; x < 3; x++) fifo[s].push_back(mk(x, y));
        end
    endtask

    task automatic cycle(bit r, int rdy, int chg, int bgs, int fgs, int emp);
        logic [N-1:0] exp_rd;
        int sel_v [2];
        bit rdy_v [2];
        bit own [2];
        bit push;
        logic [W-1:0] w;
        @(negedge clk);
        rst = r;
        if (bgs >= 0) bg_sel = SW'(bgs); else if ($urandom_range(0, 99) < chg) bg_sel = SW'($urandom_range(0, 3));
        if (fgs >= 0) fg_sel = SW'(fgs); else if ($urandom_range(0, 99) < chg) fg_sel = SW'($urandom_range(0, 3));
        bg_ready = $urandom_range(0, 99) < rdy;
        fg_ready = $urandom_range(0, 99) < rdy;
        for (int s = 0; s < N; s++) begin
            refill(s);
            src_empty[s] = r || ($urandom_range(0, 99) < emp);
            src_data[s*W +: W] = fifo[s][0];
        end
        #1;
        sel_v[0] = int'(bg_sel); sel_v[1] = int'(fg_sel);
        rdy_v[0] = bg_ready; rdy_v[1] = fg_ready;
        if (r) begin
            for (int o = 0; o < 2; o++) begin
                act_m[o] = sel_v[o]; cnt_m[o] = 0; synced[o] = 0; held[o] = 0;
                exp_q[o].delete();
            end
            return;
        end
        check("bg_valid", 64'(bg_valid), 64'(held[0]));
        check("fg_valid", 64'(fg_valid), 64'(held[1]));
        check("bg_locked", 64'(bg_locked), 64'(synced[0]));
        check("fg_locked", 64'(fg_locked), 64'(synced[1]));
        check("bg_discard_cnt", 64'(bg_discard_cnt), 64'(cnt_m[0]));
        check("fg_discard_cnt", 64'(fg_discard_cnt), 64'(cnt_m[1]));
        for (int o = 0; o < 2; o++) own[o] = sel_v[o] == act_m[o] && act_m[o] < N;
        for (int s = 0; s < N; s++) begin
            exp_rd[s] = !src_empty[s];
            for (int o = 0; o < 2; o++)
                if (own[o] && act_m[o] == s && held[o] && !rdy_v[o]) exp_rd[s] = 1'b0;
        end
        check("src_read", 64'(src_read), 64'(exp_rd));
        for (int o = 0; o < 2; o++) begin
            push = 0;
            if (own[o] && exp_rd[act_m[o]]) begin
                w = fifo[act_m[o]][0];
                if (synced[o] || (w[W-1 -: P] == 0 && w[PX +: P] == 0)) begin
                    synced[o] = 1;
                    exp_q[o].push_back(w);
                    push = 1;
                end else if (cnt_m[o] < 65535) cnt_m[o]++;
            end
            held[o] = push || (held[o] && !rdy_v[o]);
            if (sel_v[o] != act_m[o]) begin
                act_m[o] = sel_v[o]; synced[o] = 0; cnt_m[o] = 0;
            end
        end
        for (int s = 0; s < N; s++) if (exp_rd[s]) void'(fifo[s].pop_front());
    endtask

    task automatic take(int o, logic v, logic r, logic [W-1:0] d);
        logic [W-1:0] w;
        if (!(v && r)) return;
        xfers++;
        if (exp_q[o].size() == 0) check(o == 0 ? "bg_unexpected_word" : "fg_unexpected_word", 64'(d), 64'd0);
        else begin
            w = exp_q[o].pop_front();
            check(o == 0 ? "bg_data" : "fg_data", 64'(d), 64'(w));
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            take(0, bg_valid, bg_ready, bg_data);
            take(1, fg_valid, fg_ready, fg_data);
        end
    end

    initial begin
        rst = 1; bg_sel = 0; fg_sel = 1; bg_ready = 0; fg_ready = 0;
        src_empty = '1; src_data = '0;
        repeat (3) cycle(1, 100, 0, 0, 1, 20);
        cycle(0, 100, 0, 0, 1, 20);
        check("reset_bg_data", 64'(bg_data), 64'd0);
        check("reset_fg_data", 64'(fg_data), 64'd0);
        repeat (3000) cycle(0, 80, 1, -1, -1, 20);
        repeat (1000) cycle(0, 50, 0, 0, 0, 20);
        repeat (500) cycle(0, 70, 0, 3, -1, 20);
        repeat (500) cycle(0, 60, 2, -1, -1, 10);
        cycle(1, 100, 0, 0, 1, 20);
        repeat (1000) cycle(0, 90, 0, 0, 1, 10);
        junk_only = 1;
        repeat (20) cycle(0, 100, 0, 2, 1, 0);
        repeat (65600) cycle(0, 100, 0, 0, 1, 0);
        check("bg_discard_saturated", 64'(bg_discard_cnt), 64'hFFFF);
        check("transfers_seen", 64'(xfers > 100), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_source_router.md
Name: video_source_router

Overview:
- Generalised N-channel successor to the fixed ADC-to-consumer wiring: routes any of NUM_SOURCES ADC pixel FIFOs to two consumers, background (graphics pipeline bg input) and foreground (SRAM write port).
- Source selection is runtime-controllable; switching is frame-aligned so consumers never see a partial frame.
- Unselected FIFOs are drained continuously so they never overflow.
- Sits in the clk80 domain between the ADC FIFO read ports and the pipeline/SRAM wrapper.

Parameters:
- NUM_SOURCES, 2, number of ADC FIFO channels (1..8).
- PRECISION, 11, bit width of pixel_x / pixel_y.
- PIXEL_SIZE, 16, pixel colour width.
- SEL_WIDTH, 3, select bus width; must satisfy 2^SEL_WIDTH >= NUM_SOURCES.
- WORD_W, derived as 2*PRECISION+PIXEL_SIZE (38 at defaults); FIFO word layout {x, y, data}, MSB first.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- src_data  in  NUM_SOURCES*WORD_W  FWFT FIFO heads; channel i occupies bits [i*WORD_W +: WORD_W].
- src_empty  in  NUM_SOURCES  per-channel FIFO empty.
- src_read  out  NUM_SOURCES  per-channel pop (rd_en).
- bg_sel  in  SEL_WIDTH  requested background source.
- fg_sel  in  SEL_WIDTH  requested foreground source.
- bg_data  out  WORD_W  background word {x, y, pixel}.
- bg_valid  out  1  bg_data valid.
- bg_ready  in  1  background consumer accepts.
- fg_data  out  WORD_W  foreground word.
- fg_valid  out  1  fg_data valid.
- fg_ready  in  1  foreground consumer accepts.
- bg_locked  out  1  bg output is in RUN.
- fg_locked  out  1  fg output is in RUN.
- bg_discard_cnt  out  16  words discarded during the current/last bg SYNC; saturating.
- fg_discard_cnt  out  16  same, for fg.

Behaviour:
- Reset: all outputs 0; both FSMs enter SYNC; active_sel registers load bg_sel/fg_sel.
- Per output (bg, fg identical): registered active_sel, FSM {SYNC, RUN}, one output register (data + valid).
- Transfer (output register move): valid clears when valid && ready.
- can_accept = ~valid | ready.
- Pop rule for source s:
  - s not equal to either active_sel: src_read[s] = ~src_empty[s] (drain, discard).
  - s equal to one or both active_sel: src_read[s] = ~src_empty[s] AND can_accept of every output whose active_sel == s.
  - Shared source with a stalled consumer therefore stalls both outputs.
- On a pop of source s, for each output with active_sel == s:
  - SYNC, head x==0 && y==0: load output register, set valid, go to RUN.
  - SYNC, any other head: discard and increment discard_cnt (saturate at 16'hFFFF).
  - RUN: load output register, set valid.
- Latency: word popped in cycle N appears on *_data/*_valid in cycle N+1. Throughput is 1 word/cycle with ready held high.
- Select change:
  - Every cycle, if the sel input != active_sel, active_sel takes the new value, FSM goes to SYNC, and discard_cnt clears to 0.
  - Same cycle: no pop is attributed to this output; the old source is treated as unselected by this output from that cycle.
  - A word already in the output register stays valid until accepted.
- Out-of-range sel (>= NUM_SOURCES): output held in SYNC, never loads; locked=0. Every source unselected by this output is drained.
- RUN does not re-check x/y; frame integrity is guaranteed by the FIFO source.
- Mid-operation rst: FSMs go to SYNC, valids drop, and pending output words are lost.
- *_locked is the registered FSM state; it rises in the same cycle the frame-start word becomes valid.

Test Plan:
- NUM_SOURCES=2, bg_sel=0, fg_sel=1, src0 delivers (5,3), (6,3), then (0,0), (1,0) -> bg discards 2 (bg_discard_cnt=2); bg_valid with x=0,y=0 one cycle after its pop; bg_locked=1; src1 independent on fg.
- bg_sel=fg_sel=0, both locked, fg_ready low for 4 cycles -> src_read[0]=0 for those cycles after fg register fills; no word lost or duplicated on either output; src1 drained (src_read[1]=~src_empty[1]).
- Locked on src0, bg_sel switched to 1 mid-frame while bg_valid=1, bg_ready=0 -> held word remains until ready; bg_locked=0; resumes only at src1 (0,0); bg_discard_cnt resets then counts src1 pre-frame words.
- bg_sel=3 with NUM_SOURCES=2 -> bg_valid stays 0, bg_locked=0, both FIFOs drained unless fg-selected.
- Streaming 800x600 frame with ready=1 -> 480000 words out in order; then rst asserted mid-frame -> next cycle bg_valid=0, bg_locked=0; relock at next (0,0).
- 70000 non-frame-start words in SYNC -> discard_cnt saturates at 65535.
